// File: rtl/snc_pkg.sv
// Shared definitions for the spike scheduler: geometry, packet layout, FSM states.
package snc_pkg;

    localparam int unsigned NUM_AXONS = 256;
    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned AXON_W    = $clog2(NUM_AXONS);
    localparam int unsigned DLY_W     = $clog2(NUM_SLOTS);
    localparam int unsigned PKT_W     = 32;
    localparam int unsigned AXON_LSB  = 0;
    localparam int unsigned DLY_LSB   = AXON_W;
    localparam int unsigned FIELD_W   = AXON_W + DLY_W;
    localparam int unsigned MISS_W    = 8;

    // Meaningful low bits of a router packet; higher packet bits are ignored.
    typedef struct packed {
        logic [DLY_W-1:0]  delay;
        logic [AXON_W-1:0] axon;
    } spike_pkt_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    function automatic logic [AXON_W-1:0] pkt_axon(input logic [FIELD_W-1:0] f);
        spike_pkt_t p;
        p = spike_pkt_t'(f);
        return p.axon;
    endfunction

    function automatic logic [DLY_W-1:0] pkt_delay(input logic [FIELD_W-1:0] f);
        spike_pkt_t p;
        p = spike_pkt_t'(f);
        return p.delay;
    endfunction

endpackage

// File: rtl/sched_slot_mem.sv
// Circular delay buffer: one axon bit-vector per tick slot.
module sched_slot_mem #(
    parameter int unsigned NUM_AXONS = 256,
    parameter int unsigned NUM_SLOTS = 16,
    localparam int unsigned AXON_W   = $clog2(NUM_AXONS),
    localparam int unsigned DLY_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 set_en_i,
    input  logic [DLY_W-1:0]     set_slot_i,
    input  logic [AXON_W-1:0]    set_axon_i,
    input  logic                 rc_en_i,
    input  logic [DLY_W-1:0]     rc_slot_i,
    output logic [NUM_AXONS-1:0] rc_data_c,
    input  logic                 clr_en_i,
    input  logic [DLY_W-1:0]     clr_slot_i
);

    logic [NUM_AXONS-1:0] slot_q [NUM_SLOTS];

    // Clearing (init or read-and-clear) wins over a bit set into the same slot;
    // the top merges such a packet into the delivered vector instead.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if ((clr_en_i && clr_slot_i == DLY_W'(s)) ||
                (rc_en_i  && rc_slot_i  == DLY_W'(s))) begin
                slot_q[s] <= '0;
            end else if (set_en_i && set_slot_i == DLY_W'(s)) begin
                slot_q[s][set_axon_i] <= 1'b1;
            end
        end
    end

    assign rc_data_c = slot_q[rc_slot_i];

endmodule

// File: rtl/spike_scheduler.sv
// Per-core spike scheduler: buffers delayed spikes and releases one axon vector per tick.
module spike_scheduler
    import snc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [PKT_W-1:0]     pkt_data,
    output logic                 pkt_ready,
    input  logic                 tick,
    output logic                 axon_valid,
    output logic [NUM_AXONS-1:0] axon_vec,
    input  logic                 axon_ready,
    output logic [MISS_W-1:0]    tick_miss
);

    sched_state_t         state_q, state_d;
    logic [DLY_W-1:0]     ptr_q, ptr_d;
    logic [DLY_W-1:0]     init_q, init_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic [NUM_AXONS-1:0] vec_q, vec_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;

    logic [AXON_W-1:0]    pkt_ax;
    logic [DLY_W-1:0]     pkt_dly;
    logic [DLY_W-1:0]     set_slot;
    logic                 accept;
    logic [NUM_AXONS-1:0] merge_vec;
    logic [NUM_AXONS-1:0] rd_vec;
    logic [MISS_W-1:0]    miss_inc;
    logic                 clr_en_c;
    logic                 rc_en_c;
    logic                 unused_pkt_hi;

    // Packet decode and target slot (wraps modulo the buffer depth).
    assign pkt_ax        = pkt_axon(pkt_data[FIELD_W-1:0]);
    assign pkt_dly       = pkt_delay(pkt_data[FIELD_W-1:0]);
    assign unused_pkt_hi = ^pkt_data[PKT_W-1:FIELD_W];
    assign accept        = pkt_valid && ready_q;
    assign set_slot      = DLY_W'(ptr_q + pkt_dly);
    assign merge_vec     = (accept && set_slot == ptr_q) ? (NUM_AXONS'(1) << pkt_ax) : '0;
    assign miss_inc      = (miss_q == '1) ? miss_q : MISS_W'(miss_q + 1'b1);

    sched_slot_mem #(
        .NUM_AXONS (NUM_AXONS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_mem (
        .clk        (clk),
        .set_en_i   (accept),
        .set_slot_i (set_slot),
        .set_axon_i (pkt_ax),
        .rc_en_i    (rc_en_c),
        .rc_slot_i  (ptr_q),
        .rc_data_c  (rd_vec),
        .clr_en_i   (clr_en_c),
        .clr_slot_i (init_q)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            init_q  <= '0;
            miss_q  <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            init_q  <= init_d;
            miss_q  <= miss_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Next-state: slot clearing, tick capture, delivery handshake, dropped-tick count.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        init_d   = init_q;
        miss_d   = miss_q;
        vec_d    = vec_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
        clr_en_c = 1'b0;
        rc_en_c  = 1'b0;
        unique case (state_q)
            INIT: begin
                clr_en_c = 1'b1;
                init_d   = DLY_W'(init_q + 1'b1);
                if (tick) miss_d = miss_inc;
                if (init_q == DLY_W'(NUM_SLOTS - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (tick) begin
                    rc_en_c = 1'b1;
                    vec_d   = rd_vec | merge_vec;
                    ptr_d   = DLY_W'(ptr_q + 1'b1);
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick) miss_d = miss_inc;
                if (axon_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
                ready_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign pkt_ready  = ready_q;
    assign axon_valid = valid_q;
    assign axon_vec   = vec_q;
    assign tick_miss  = miss_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// Self-checking bench for spike_scheduler against a pending-spike countdown model.
module tb_spike_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [31:0]  pkt_data = '0;
    logic         tick = 1'b0;
    logic         axon_ready = 1'b0;
    logic         pkt_ready;
    logic         axon_valid;
    logic [255:0] axon_vec;
    logic [7:0]   tick_miss;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each pending spike counts down the accepted ticks until it is due.
    typedef struct {
        int axon;
        int left;
    } pend_t;
    pend_t        pend[$];
    int           m_init_left;
    bit           m_drain;
    int           m_miss;
    logic [255:0] m_vec;

    spike_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .tick       (tick),
        .axon_valid (axon_valid),
        .axon_vec   (axon_vec),
        .axon_ready (axon_ready),
        .tick_miss  (tick_miss)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_pkt(input int axon, input int dly);
        logic [19:0] junk;
        junk = 20'($urandom);
        return {junk, 4'(dly), 8'(axon)};
    endfunction

    function automatic logic [255:0] bit_vec(input int axon);
        logic [255:0] v;
        v = '0;
        v[axon] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_init_left = 16;
        m_drain     = 1'b0;
        m_miss      = 0;
        m_vec       = '0;
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model, settle.
    task automatic cyc(input bit v, input logic [31:0] d, input bit t, input bit r);
        pend_t p;
        logic [255:0] nv;
        pkt_valid  = v;
        pkt_data   = d;
        tick       = t;
        axon_ready = r;
        @(posedge clk);
        if (m_init_left > 0) begin
            if (t && m_miss < 255) m_miss++;
            m_init_left--;
        end else begin
            if (v) begin
                p.axon = int'(d[7:0]);
                p.left = int'(d[11:8]) + 1;
                pend.push_back(p);
            end
            if (!m_drain) begin
                if (t) begin
                    nv = '0;
                    for (int i = pend.size() - 1; i >= 0; i--) begin
                        pend[i].left--;
                        if (pend[i].left == 0) begin
                            nv[pend[i].axon] = 1'b1;
                            pend.delete(i);
                        end
                    end
                    m_vec   = nv;
                    m_drain = 1'b1;
                end
            end else begin
                if (t && m_miss < 255) m_miss++;
                if (r) m_drain = 1'b0;
            end
        end
        #1;
        pkt_valid = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic do_reset(input bit wait_init);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (wait_init) repeat (16) cyc(0, '0, 0, 1);
    endtask

    // Tick from IDLE and complete the handshake; returns what was presented.
    task automatic tick_deliver(output logic [255:0] got, output logic got_v);
        cyc(0, '0, 1, 1);
        got   = axon_vec;
        got_v = axon_valid;
        cyc(0, '0, 0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #2;
        n_cmp++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_ready got=%b exp=0", pkt_ready); end
        n_cmp++; if (axon_valid !== 1'b0) begin n_bad++; $display("FAIL reset_axon_valid got=%b exp=0", axon_valid); end
        n_cmp++; if (axon_vec !== '0) begin n_bad++; $display("FAIL reset_axon_vec got=%h exp=0", axon_vec); end
        n_cmp++; if (tick_miss !== 8'd0) begin n_bad++; $display("FAIL reset_tick_miss got=%0d exp=0", tick_miss); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            cyc(0, '0, 0, 1);
            n_cmp++; if (pkt_ready !== (c >= 16)) begin n_bad++; $display("FAIL init_pkt_ready cycle=%0d got=%b exp=%b", c, pkt_ready, c >= 16); end
            n_cmp++; if (axon_valid !== 1'b0 || tick_miss !== 8'd0) begin n_bad++; $display("FAIL init_quiet cycle=%0d valid=%b miss=%0d exp 0/0", c, axon_valid, tick_miss); end
        end
    endtask

    task automatic test_single();
        logic [255:0] got;
        logic         gv;
        cyc(1, mk_pkt(5, 0), 0, 1);
        tick_deliver(got, gv);
        n_cmp++; if (gv !== 1'b1 || got !== bit_vec(5)) begin n_bad++; $display("FAIL single_bit5 valid=%b got=%h exp=%h", gv, got, bit_vec(5)); end
        tick_deliver(got, gv);
        n_cmp++; if (gv !== 1'b1 || got !== '0) begin n_bad++; $display("FAIL single_empty valid=%b got=%h exp=0", gv, got); end
    endtask

    task automatic test_delay();
        logic [255:0] got;
        logic         gv;
        cyc(1, mk_pkt(200, 3), 0, 1);
        cyc(1, mk_pkt(200, 3), 0, 1);
        for (int k = 1; k <= 4; k++) begin
            tick_deliver(got, gv);
            n_cmp++; if (gv !== 1'b1 || got !== ((k == 4) ? bit_vec(200) : '0)) begin n_bad++; $display("FAIL delay3 tick=%0d valid=%b got=%h", k, gv, got); end
        end
    endtask

    task automatic test_wrap();
        logic [255:0] got;
        logic         gv;
        do_reset(1);
        repeat (14) tick_deliver(got, gv);
        cyc(1, mk_pkt(9, 5), 0, 1);
        for (int k = 1; k <= 6; k++) begin
            tick_deliver(got, gv);
            n_cmp++; if (gv !== 1'b1 || got !== ((k == 6) ? bit_vec(9) : '0)) begin n_bad++; $display("FAIL wrap tick=%0d valid=%b got=%h", k, gv, got); end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] v0, got;
        logic         gv;
        do_reset(1);
        cyc(1, mk_pkt(33, 0), 0, 1);
        cyc(1, mk_pkt(77, 1), 0, 1);
        cyc(0, '0, 1, 0);
        v0 = axon_vec;
        n_cmp++; if (axon_valid !== 1'b1 || v0 !== bit_vec(33)) begin n_bad++; $display("FAIL bp_first valid=%b got=%h exp=%h", axon_valid, v0, bit_vec(33)); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, i == 1, 0);
            n_cmp++; if (axon_valid !== 1'b1 || axon_vec !== v0) begin n_bad++; $display("FAIL bp_hold cycle=%0d valid=%b got=%h exp=%h", i, axon_valid, axon_vec, v0); end
        end
        n_cmp++; if (tick_miss !== 8'd1) begin n_bad++; $display("FAIL bp_miss got=%0d exp=1", tick_miss); end
        cyc(0, '0, 0, 1);
        n_cmp++; if (axon_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got=%b exp=0", axon_valid); end
        tick_deliver(got, gv);
        n_cmp++; if (gv !== 1'b1 || got !== bit_vec(77)) begin n_bad++; $display("FAIL bp_next valid=%b got=%h exp=%h", gv, got, bit_vec(77)); end
        // Tick coincident with the completing handshake is dropped.
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 1);
        n_cmp++; if (tick_miss !== 8'd2 || axon_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop miss=%0d valid=%b exp 2/0", tick_miss, axon_valid); end
        cyc(0, '0, 1, 1);
        n_cmp++; if (axon_valid !== 1'b1 || tick_miss !== 8'd2) begin n_bad++; $display("FAIL b2b_next valid=%b miss=%0d exp 1/2", axon_valid, tick_miss); end
        cyc(0, '0, 0, 1);
    endtask

    task automatic test_same_cycle();
        cyc(1, mk_pkt(7, 0), 1, 0);
        n_cmp++; if (axon_valid !== 1'b1 || axon_vec !== bit_vec(7)) begin n_bad++; $display("FAIL same_cycle valid=%b got=%h exp=%h", axon_valid, axon_vec, bit_vec(7)); end
        cyc(0, '0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (axon_valid !== 1'b0 || pkt_ready !== 1'b0 || tick_miss !== 8'd0 || axon_vec !== '0) begin n_bad++; $display("FAIL async_reset valid=%b ready=%b miss=%0d vec=%h", axon_valid, pkt_ready, tick_miss, axon_vec); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            cyc(0, '0, 0, 1);
            n_cmp++; if (pkt_ready !== (c == 16)) begin n_bad++; $display("FAIL reinit_ready cycle=%0d got=%b exp=%b", c, pkt_ready, c == 16); end
        end
    endtask

    task automatic test_saturate();
        do_reset(1);
        repeat (300) cyc(0, '0, 1, 0);
        n_cmp++; if (tick_miss !== 8'd255) begin n_bad++; $display("FAIL miss_saturate got=%0d exp=255", tick_miss); end
        cyc(0, '0, 0, 1);
    endtask

    task automatic test_random();
        bit v, t, r;
        do_reset(0);
        for (int c = 0; c < 800; c++) begin
            v = ($urandom_range(0, 1) == 1);
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) != 0);
            cyc(v, $urandom, t, r);
            n_cmp++; if (pkt_ready !== (m_init_left == 0)) begin n_bad++; $display("FAIL rnd_ready cycle=%0d got=%b exp=%b", c, pkt_ready, m_init_left == 0); end
            n_cmp++; if (axon_valid !== m_drain) begin n_bad++; $display("FAIL rnd_valid cycle=%0d got=%b exp=%b", c, axon_valid, m_drain); end
            n_cmp++; if (tick_miss !== 8'(m_miss)) begin n_bad++; $display("FAIL rnd_miss cycle=%0d got=%0d exp=%0d", c, tick_miss, m_miss); end
            if (m_drain) begin
                n_cmp++; if (axon_vec !== m_vec) begin n_bad++; $display("FAIL rnd_vec cycle=%0d got=%h exp=%h", c, axon_vec, m_vec); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_delay();
        test_wrap();
        test_backpressure();
        test_same_cycle();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
